// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-memory / MMIO bridge: register offsets,
// STATUS bit positions and the serializer state encoding.
package dmem_mmio_pkg;

  localparam logic [11:0] LED_OFS    = 12'd0;
  localparam logic [11:0] TXDATA_OFS = 12'd1;
  localparam logic [11:0] STATUS_OFS = 12'd2;
  localparam logic [11:0] CYCLE_OFS  = 12'd3;

  localparam int ST_EMPTY_BIT  = 0;
  localparam int ST_FULL_BIT   = 1;
  localparam int ST_BUSY_BIT   = 2;
  localparam int ST_OVF_BIT    = 3;
  localparam int ST_COUNT_LSB  = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/dmem_mmio_bridge_fifo.sv
// Synchronous byte FIFO feeding the serial transmitter. A push is refused
// whenever the FIFO is full, even if a pop happens in the same cycle.
module mmio_tx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [7:0]                    pushData,
  input  logic                          pop,
  output logic [7:0]                    popData,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign popData  = r_mem[r_rdPtr];
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (w_doPush) r_mem[r_wrPtr] <= pushData;
  end

  // Pointers wrap for free because the depth is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Data-memory port decoder: dmem passthrough below MMIO_BASE, LED/UART/STATUS/
// CYCLE registers above it. CYCLE exists only when MMIO_CYCLE_COUNTER_EN is defined.
module dmem_mmio_bridge
  import dmem_mmio_pkg::*;
#(
  parameter logic [11:0] MMIO_BASE  = 12'hF00,
  parameter int          FIFO_DEPTH = 8,
  parameter int          BAUD_DIV   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] proc_address,
  input  logic [31:0] proc_data,
  input  logic        proc_wren,
  output logic [31:0] proc_q,
  output logic [11:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_q,
  output logic [15:0] led,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BAUD_DIV);

  logic          w_inWindow;
  logic [11:0]   w_offset;
  logic          w_wrLed;
  logic          w_wrTx;
  logic          w_wrStatus;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_popData;
  logic          w_pop;
  logic          w_baudDone;
  logic [31:0]   w_status;
  logic [31:0]   w_cycleRd;
  logic [31:0]   w_rdData;

  logic          r_sel;
  logic [31:0]   r_rdData;
  logic [15:0]   r_led;
  logic          r_ovf;
  tx_state_e     r_state;
  logic [7:0]    r_shift;
  logic [BW-1:0] r_baudCnt;
  logic [2:0]    r_bitCnt;
  logic          r_tx;

  assign w_inWindow = (proc_address >= MMIO_BASE);
  assign w_offset   = proc_address - MMIO_BASE;
  assign w_wrLed    = proc_wren && w_inWindow && (w_offset == LED_OFS);
  assign w_wrTx     = proc_wren && w_inWindow && (w_offset == TXDATA_OFS);
  assign w_wrStatus = proc_wren && w_inWindow && (w_offset == STATUS_OFS);

  assign mem_address = proc_address;
  assign mem_data    = proc_data;
  assign mem_wren    = proc_wren && !w_inWindow;
  assign proc_q      = r_sel ? r_rdData : mem_q;
  assign led         = r_led;
  assign tx          = r_tx;

  mmio_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (w_wrTx),
    .pushData (proc_data[7:0]),
    .pop      (w_pop),
    .popData  (w_popData),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count)
  );

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;

  always_ff @(posedge clock) begin
    if (reset) r_cycle <= '0;
    else       r_cycle <= r_cycle + 32'd1;
  end

  assign w_cycleRd = r_cycle;
`else
  assign w_cycleRd = '0;
`endif

  always_comb begin
    w_status = '0;
    w_status[ST_EMPTY_BIT]       = w_empty;
    w_status[ST_FULL_BIT]        = w_full;
    w_status[ST_BUSY_BIT]        = (r_state != TX_IDLE);
    w_status[ST_OVF_BIT]         = r_ovf;
    w_status[ST_COUNT_LSB +: 4]  = 4'(w_count);
  end

  always_comb begin
    w_rdData = '0;
    case (w_offset)
      LED_OFS:    w_rdData = {16'h0000, r_led};
      STATUS_OFS: w_rdData = w_status;
      CYCLE_OFS:  w_rdData = w_cycleRd;
      default:    w_rdData = '0;
    endcase
  end

  // The read value is captured at the same edge the address is presented,
  // so it lines up with the one-cycle latency of the dmem syncram.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sel    <= 1'b0;
      r_rdData <= '0;
      r_led    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_sel    <= w_inWindow;
      r_rdData <= w_rdData;
      if (w_wrLed) r_led <= proc_data[15:0];
      if (w_wrTx && w_full)
        r_ovf <= 1'b1;
      else if (w_wrStatus && proc_data[ST_OVF_BIT])
        r_ovf <= 1'b0;
    end
  end

  assign w_pop      = (r_state == TX_IDLE) && !w_empty;
  assign w_baudDone = (r_baudCnt == BW'(BAUD_DIV - 1));

  // tx is registered and updated on the edge that enters each bit, so the
  // start bit appears right after the pop edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= TX_IDLE;
      r_shift   <= '0;
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift   <= w_popData;
            r_baudCnt <= '0;
            r_tx      <= 1'b0;
            r_state   <= TX_START;
          end
        end
        TX_START: begin
          if (w_baudDone) begin
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_tx      <= r_shift[0];
            r_state   <= TX_DATA;
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_baudDone) begin
            r_baudCnt <= '0;
            if (r_bitCnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
              r_shift  <= r_shift >> 1;
              r_tx     <= r_shift[1];
            end
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (w_baudDone) begin
            r_baudCnt <= '0;
            r_tx      <= 1'b1;
            r_state   <= TX_IDLE;
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule
